// File: rtl/sig_input_conditioner_if.sv
// rtl/sig_input_conditioner_if.sv - button conditioner signal bundle
// master = IOCtrl/test side driving raw levels and clears; slave = conditioner.
interface sig_input_conditioner_if #(
  parameter int NUM_SIG = 3
);
  logic [NUM_SIG-1:0] sigIn;
  logic [NUM_SIG-1:0] stickyClr;
  logic [NUM_SIG-1:0] sigLevel;
  logic [NUM_SIG-1:0] sigRise;
  logic [NUM_SIG-1:0] sigFall;
  logic [NUM_SIG-1:0] sigSticky;

  modport master (
    output sigIn,
    output stickyClr,
    input  sigLevel,
    input  sigRise,
    input  sigFall,
    input  sigSticky
  );

  modport slave (
    input  sigIn,
    input  stickyClr,
    output sigLevel,
    output sigRise,
    output sigFall,
    output sigSticky
  );
endinterface

// File: rtl/sig_input_conditioner.sv
// rtl/sig_input_conditioner.sv - per-channel sync, debounce, edge pulses and sticky press latch
// Optional auto-repeat of sigRise while held is enabled by defining SIG_AUTOREPEAT_EN.
module sig_input_conditioner #(
  parameter int NUM_SIG         = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  sig_input_conditioner_if.slave  bus
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || RPT_MAX < 1) begin : g_bad_param
    $error("sig_input_conditioner: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_LO,
    S_CHK_HI,
    S_HI,
    S_CHK_LO
  } state_t;

  state_t             state_q [NUM_SIG];
  state_t             state_d [NUM_SIG];
  logic [CNT_W-1:0]   cnt_q   [NUM_SIG];
  logic [CNT_W-1:0]   cnt_d   [NUM_SIG];

  logic [NUM_SIG-1:0] sync1_q, sync1_d;
  logic [NUM_SIG-1:0] sync2_q, sync2_d;
  logic [NUM_SIG-1:0] level_q, level_d;
  logic [NUM_SIG-1:0] rise_q, rise_d;
  logic [NUM_SIG-1:0] fall_q, fall_d;
  logic [NUM_SIG-1:0] sticky_q, sticky_d;

`ifdef SIG_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0]   rpt_q [NUM_SIG];
  logic [RPT_W-1:0]   rpt_d [NUM_SIG];
  // Set once the first (REPEAT_DELAY) pulse has fired; later pulses use REPEAT_PERIOD.
  logic [NUM_SIG-1:0] rep_q, rep_d;
`endif

  always_comb begin
    sync1_d = bus.sigIn;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < NUM_SIG; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef SIG_AUTOREPEAT_EN
      rpt_d[i]   = '0;
      rep_d[i]   = 1'b0;
`endif
      case (state_q[i])
        S_LO: begin
          if (sync2_q[i]) begin
            state_d[i] = S_CHK_HI;
            cnt_d[i]   = CNT_W'(1);
          end else begin
            cnt_d[i]   = '0;
          end
        end
        S_CHK_HI: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_LO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d[i] = S_HI;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            rise_d[i]  = 1'b1;
          end else if (cnt_q[i] != CNT_W'(DEBOUNCE_CYCLES)) begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        S_HI: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_CHK_LO;
            cnt_d[i]   = CNT_W'(1);
          end
`ifdef SIG_AUTOREPEAT_EN
          else if ((!rep_q[i] && rpt_q[i] == RPT_W'(REPEAT_DELAY - 1)) ||
                   ( rep_q[i] && rpt_q[i] == RPT_W'(REPEAT_PERIOD - 1))) begin
            rise_d[i] = 1'b1;
            rpt_d[i]  = '0;
            rep_d[i]  = 1'b1;
          end else begin
            rpt_d[i]  = rpt_q[i] + RPT_W'(1);
            rep_d[i]  = rep_q[i];
          end
`endif
        end
        S_CHK_LO: begin
          if (sync2_q[i]) begin
            state_d[i] = S_HI;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d[i] = S_LO;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
            fall_d[i]  = 1'b1;
          end else if (cnt_q[i] != CNT_W'(DEBOUNCE_CYCLES)) begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = S_LO;
          cnt_d[i]   = '0;
        end
      endcase
    end
    // A new press sets the latch even when IOCtrl clears in the same cycle.
    sticky_d = rise_d | (sticky_q & ~bus.stickyClr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
      for (int i = 0; i < NUM_SIG; i++) begin
        state_q[i] <= S_LO;
        cnt_q[i]   <= '0;
`ifdef SIG_AUTOREPEAT_EN
        rpt_q[i]   <= '0;
`endif
      end
`ifdef SIG_AUTOREPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
      for (int i = 0; i < NUM_SIG; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef SIG_AUTOREPEAT_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
`ifdef SIG_AUTOREPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  assign bus.sigLevel  = level_q;
  assign bus.sigRise   = rise_q;
  assign bus.sigFall   = fall_q;
  assign bus.sigSticky = sticky_q;

endmodule
